// File: rtl/morse_stream_decoder.sv
// Morse symbol accumulator and ITU decoder with a valid/ready character register.
// Define MORSE_PUNCT_EN to also decode . , ? / = patterns.
module morse_stream_decoder #(
  parameter int          MAX_LEN      = 6,
  parameter logic [7:0]  IDLE_CHAR    = 8'h2D,
  parameter logic [7:0]  INVALID_CHAR = 8'h20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sym_valid,
  input  logic [1:0] i_sym_code,
  input  logic       i_letter_done,
  input  logic       i_char_ready,
  output logic [7:0] o_ascii_char,
  output logic       o_char_valid,
  output logic [2:0] o_sym_count,
  output logic       o_overflow,
  output logic       o_overrun
);

  // state      | meaning
  // ST_EMPTY   | no character awaiting the consumer
  // ST_PENDING | o_ascii_char holds a character not yet accepted
  typedef enum logic {ST_EMPTY, ST_PENDING} state_t;

  localparam logic [2:0] LP_MAX = 3'(MAX_LEN);

  state_t     r_state, w_state_nxt;
  logic [5:0] r_pat, w_pat_eff;
  logic [2:0] r_count, w_len_eff;
  logic       r_ovf, w_ovf_eff;
  logic [7:0] r_char, w_char;
  logic       r_overrun, w_overrun_nxt;
  logic       w_sym_ok, w_store, w_decode;

  // pat[i] is symbol i (1 = dash); code is rebuilt first-symbol-MSB for table lookup
  function automatic logic [7:0] f_decode(input logic [2:0] len, input logic [5:0] pat);
    logic [5:0] code;
    logic [7:0] ch;
    code = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < int'(len)) code = {code[4:0], pat[i]};
    end
    ch = INVALID_CHAR;
    case (len)
      3'd1: ch = code[0] ? "T" : "E";
      3'd2: begin
        case (code[1:0])
          2'b00:   ch = "I";
          2'b01:   ch = "A";
          2'b10:   ch = "N";
          default: ch = "M";
        endcase
      end
      3'd3: begin
        case (code[2:0])
          3'b000:  ch = "S";
          3'b001:  ch = "U";
          3'b010:  ch = "R";
          3'b011:  ch = "W";
          3'b100:  ch = "D";
          3'b101:  ch = "K";
          3'b110:  ch = "G";
          default: ch = "O";
        endcase
      end
      3'd4: begin
        case (code[3:0])
          4'b0000: ch = "H";
          4'b0001: ch = "V";
          4'b0010: ch = "F";
          4'b0100: ch = "L";
          4'b0110: ch = "P";
          4'b0111: ch = "J";
          4'b1000: ch = "B";
          4'b1001: ch = "X";
          4'b1010: ch = "C";
          4'b1011: ch = "Y";
          4'b1100: ch = "Z";
          4'b1101: ch = "Q";
          default: ch = INVALID_CHAR;
        endcase
      end
      3'd5: begin
        case (code[4:0])
          5'b00000: ch = "5";
          5'b00001: ch = "4";
          5'b00011: ch = "3";
          5'b00111: ch = "2";
          5'b01111: ch = "1";
          5'b10000: ch = "6";
          5'b11000: ch = "7";
          5'b11100: ch = "8";
          5'b11110: ch = "9";
          5'b11111: ch = "0";
`ifdef MORSE_PUNCT_EN
          5'b10010: ch = "/";
          5'b10001: ch = "=";
`endif
          default:  ch = INVALID_CHAR;
        endcase
      end
      3'd6: begin
        case (code)
`ifdef MORSE_PUNCT_EN
          6'b010101: ch = ".";
          6'b110011: ch = ",";
          6'b001100: ch = "?";
`endif
          default:   ch = INVALID_CHAR;
        endcase
      end
      default: ch = INVALID_CHAR;
    endcase
    return ch;
  endfunction

  // A same-cycle symbol is folded in before letter_done is evaluated
  always_comb begin
    w_sym_ok  = i_sym_valid & (i_sym_code[0] ^ i_sym_code[1]);
    w_store   = w_sym_ok & (r_count < LP_MAX);
    w_pat_eff = r_pat;
    if (w_store) w_pat_eff[r_count] = i_sym_code[1];
    w_len_eff = r_count + {2'b00, w_store};
    w_ovf_eff = r_ovf | (w_sym_ok & ~w_store);
    w_decode  = i_letter_done & (w_len_eff != 3'd0);
    w_char    = w_ovf_eff ? INVALID_CHAR : f_decode(w_len_eff, w_pat_eff);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_overrun_nxt = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_decode) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (w_decode) begin
          w_state_nxt   = ST_PENDING;
          w_overrun_nxt = ~i_char_ready;
        end else if (i_char_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pat   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_decode) begin
      r_pat   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pat   <= w_pat_eff;
      r_count <= w_len_eff;
      r_ovf   <= w_ovf_eff;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_EMPTY;
      r_char    <= IDLE_CHAR;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_overrun <= w_overrun_nxt;
      if (w_decode) r_char <= w_char;
    end
  end

  assign o_ascii_char = r_char;
  assign o_char_valid = (r_state == ST_PENDING);
  assign o_sym_count  = r_count;
  assign o_overflow   = r_ovf;
  assign o_overrun    = r_overrun;

endmodule
